// File: rtl/word_byte_store_pkg.sv
// Shared definitions for the word-to-byte store path: FSM states, request
// mode encodings and the mem_lh byte tags.
package word_byte_store_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

  // Request modes as seen on in_mode (2'b11 folds onto MODE_BOTH).
  typedef enum logic [1:0] {
    MODE_BOTH = 2'b00,
    MODE_LOW  = 2'b01,
    MODE_HIGH = 2'b10
  } mode_e;

  // Tag telling the register side which half of the word a byte came from.
  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  // Map the raw in_mode field onto the three real modes.
  function automatic mode_e normalize_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_LOW;
      2'b10:   return MODE_HIGH;
      default: return MODE_BOTH;
    endcase
  endfunction

endpackage

// File: rtl/word_byte_store.sv
// word_byte_store: unloads a 16-bit word onto a byte-wide memory write port
// as one or two byte writes at base / base+1, then pulses done.
// Optional build macro WORD_BYTE_STORE_PREFETCH_EN adds a one-entry holding
// register so a new request can be accepted during the final byte and
// started without an IDLE bubble.
module word_byte_store
  import word_byte_store_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_word,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_mode,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_lh,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [15:0]       word_q, word_d;
  logic [ADDR_W-1:0] base_q, base_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_lh_q, mem_lh_d;
  logic              done_q, done_d;

  // Request about to be loaded into FIRST, and the bytes derived from it.
  logic [15:0]       ld_word;
  logic [ADDR_W-1:0] ld_addr;
  mode_e             ld_mode;
  logic              first_lh;
  logic [7:0]        first_data;
  logic              second_lh;
  logic [7:0]        second_data;
  logic [ADDR_W-1:0] second_addr;

  logic handshake;
  logic final_byte;
  logic accept;
  logic load_req;

`ifdef WORD_BYTE_STORE_PREFETCH_EN
  logic              hold_valid_q, hold_valid_d;
  logic [15:0]       hold_word_q, hold_word_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  mode_e             hold_mode_q, hold_mode_d;
`endif

  assign mem_wr_en  = (state_q != ST_IDLE);
  assign busy       = mem_wr_en;
  assign handshake  = mem_wr_en && mem_ready;
  assign final_byte = (state_q == ST_SECOND) ||
                      ((state_q == ST_FIRST) && (mode_q != MODE_BOTH));
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_lh     = mem_lh_q;
  assign done       = done_q;

`ifdef WORD_BYTE_STORE_PREFETCH_EN
  // in_ready is gated by rst so it reads 0 for the whole reset window.
  assign in_ready = !rst && ((state_q == ST_IDLE) || (final_byte && !hold_valid_q));
  assign ld_word  = hold_valid_q ? hold_word_q : in_word;
  assign ld_addr  = hold_valid_q ? hold_addr_q : in_addr;
  assign ld_mode  = hold_valid_q ? hold_mode_q : normalize_mode(in_mode);
`else
  // in_ready is gated by rst so it reads 0 for the whole reset window.
  assign in_ready = !rst && (state_q == ST_IDLE);
  assign ld_word  = in_word;
  assign ld_addr  = in_addr;
  assign ld_mode  = normalize_mode(in_mode);
`endif

  assign accept = in_valid && in_ready;

  // Byte select and address offset for the first and second byte.
  always_comb begin
    if (ld_mode == MODE_LOW) begin
      first_lh = LH_LOW;
    end else if (ld_mode == MODE_HIGH) begin
      first_lh = LH_HIGH;
    end else begin
      first_lh = LOW_FIRST ? LH_LOW : LH_HIGH;
    end
    first_data  = first_lh ? ld_word[15:8] : ld_word[7:0];
    second_lh   = ~mem_lh_q;
    second_data = second_lh ? word_q[15:8] : word_q[7:0];
    second_addr = base_q + ADDR_W'(1);
  end

  // Next-state and output-register logic for the transfer FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    word_d     = word_q;
    base_d     = base_q;
    mode_d     = mode_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_lh_d   = mem_lh_q;
    done_d     = 1'b0;
    load_req   = 1'b0;
`ifdef WORD_BYTE_STORE_PREFETCH_EN
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    hold_addr_d  = hold_addr_q;
    hold_mode_d  = hold_mode_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_req = 1'b1;
        end
      end
      ST_FIRST: begin
        if (handshake && (mode_q == MODE_BOTH)) begin
          state_d    = ST_SECOND;
          mem_addr_d = second_addr;
          mem_data_d = second_data;
          mem_lh_d   = second_lh;
        end
      end
      default: ;
    endcase

    if (handshake && final_byte) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
`ifdef WORD_BYTE_STORE_PREFETCH_EN
      // Chain straight into the held (or simultaneously offered) request.
      if (hold_valid_q || accept) begin
        load_req = 1'b1;
      end
      hold_valid_d = 1'b0;
`endif
    end
`ifdef WORD_BYTE_STORE_PREFETCH_EN
    else if (accept && (state_q != ST_IDLE)) begin
      hold_valid_d = 1'b1;
      hold_word_d  = in_word;
      hold_addr_d  = in_addr;
      hold_mode_d  = normalize_mode(in_mode);
    end
`endif

    // Registering the first byte here presents it one cycle after accept.
    if (load_req) begin
      state_d    = ST_FIRST;
      word_d     = ld_word;
      base_d     = ld_addr;
      mode_d     = ld_mode;
      mem_addr_d = ld_addr;
      mem_data_d = first_data;
      mem_lh_d   = first_lh;
    end
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      base_q     <= '0;
      mode_q     <= MODE_BOTH;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_lh_q   <= LH_LOW;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      word_q     <= word_d;
      base_q     <= base_d;
      mode_q     <= mode_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_lh_q   <= mem_lh_d;
      done_q     <= done_d;
    end
  end

`ifdef WORD_BYTE_STORE_PREFETCH_EN
  // One-entry holding register for the request queued behind the active one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
      hold_addr_q  <= '0;
      hold_mode_q  <= MODE_BOTH;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      hold_addr_q  <= hold_addr_d;
      hold_mode_q  <= hold_mode_d;
    end
  end
`endif

endmodule

// File: tb/tb_word_byte_store.sv
// Bench for word_byte_store: two instances (LOW_FIRST=1 and LOW_FIRST=0)
// share the stimulus; a byte-level reference model fills a scoreboard queue
// at each accept and a negedge monitor pops and compares every memory
// handshake and done pulse. Honours WORD_BYTE_STORE_PREFETCH_EN.
`timescale 1ns/1ps
module tb_word_byte_store;

  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 400;

  typedef enum int {EV_BYTE = 0, EV_DONE = 1} ev_e;
  typedef struct {
    ev_e         kind;
    int unsigned addr;
    int unsigned data_le;
    int unsigned lh_le;
    int unsigned data_be;
    int unsigned lh_be;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [15:0]       in_word;
  logic [ADDR_W-1:0] in_addr;
  logic [1:0]        in_mode;
  logic              mem_ready;

  logic              in_ready_a, wr_en_a, lh_a, busy_a, done_a;
  logic [ADDR_W-1:0] addr_a;
  logic [7:0]        data_a;
  logic              in_ready_b, wr_en_b, lh_b, busy_b, done_b;
  logic [ADDR_W-1:0] addr_b;
  logic [7:0]        data_b;

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int ready_mode = 0;
  int stall_cnt  = 0;
  int wr_cnt     = 0;
  int done_cnt   = 0;

  exp_t exp_q[$];

  word_byte_store #(.ADDR_W(ADDR_W), .LOW_FIRST(1'b1)) u_dut_le (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_word(in_word), .in_addr(in_addr), .in_mode(in_mode),
    .mem_wr_en(wr_en_a), .mem_ready(mem_ready), .mem_addr(addr_a),
    .mem_data(data_a), .mem_lh(lh_a), .busy(busy_a), .done(done_a)
  );

  word_byte_store #(.ADDR_W(ADDR_W), .LOW_FIRST(1'b0)) u_dut_be (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_word(in_word), .in_addr(in_addr), .in_mode(in_mode),
    .mem_wr_en(wr_en_b), .mem_ready(mem_ready), .mem_addr(addr_b),
    .mem_data(data_b), .mem_lh(lh_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation pending (t=%0t)", name, $time);
  endtask

  // Reference model: the bytes a request must produce, in order, for both
  // byte orders, followed by its completion.
  function automatic void push_request(input logic [15:0] w, input logic [15:0] a,
                                       input logic [1:0] m);
    exp_t e;
    int unsigned lo, hi;
    lo = w % 256;
    hi = w / 256;
    e.kind = EV_BYTE;
    e.addr = a;
    if (m == 2'b01) begin
      e.data_le = lo; e.lh_le = 0; e.data_be = lo; e.lh_be = 0;
      exp_q.push_back(e);
    end else if (m == 2'b10) begin
      e.data_le = hi; e.lh_le = 1; e.data_be = hi; e.lh_be = 1;
      exp_q.push_back(e);
    end else begin
      e.data_le = lo; e.lh_le = 0; e.data_be = hi; e.lh_be = 1;
      exp_q.push_back(e);
      e.addr = (int'(a) + 1) % 65536;
      e.data_le = hi; e.lh_le = 1; e.data_be = lo; e.lh_be = 0;
      exp_q.push_back(e);
    end
    e.kind = EV_DONE;
    exp_q.push_back(e);
  endfunction

  // mem_ready driver: 0 = always ready, 1 = random, 2 = three stall cycles per byte.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (wr_en_a) begin
          if (stall_cnt < 3) begin
            mem_ready = 1'b0;
            stall_cnt++;
          end else begin
            mem_ready = 1'b1;
            stall_cnt = 0;
          end
        end else begin
          mem_ready = 1'b0;
          stall_cnt = 0;
        end
      end
    endcase
  end

  // Monitor: pops the scoreboard on every done pulse and byte handshake.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;
    logic        prev_lh;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    prev_lh    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_wr_en", wr_en_a, 1);
          check("hold_addr", addr_a, prev_addr);
          check("hold_data", data_a, prev_data);
          check("hold_lh", lh_a, prev_lh);
        end
        if (done_a || done_b) begin
          done_cnt++;
          check("done_le", done_a, 1);
          check("done_be", done_b, 1);
          if (exp_q.size() == 0) fail_event("unexpected_done");
          else begin
            e = exp_q.pop_front();
            check("done_order", e.kind, EV_DONE);
          end
        end
        if (mem_ready && (wr_en_a || wr_en_b)) begin
          check("wr_en_le", wr_en_a, 1);
          check("wr_en_be", wr_en_b, 1);
          if (exp_q.size() == 0) fail_event("unexpected_write");
          else begin
            e = exp_q.pop_front();
            check("byte_order", e.kind, EV_BYTE);
            check("addr_le", addr_a, e.addr);
            check("data_le", data_a, e.data_le);
            check("lh_le", lh_a, e.lh_le);
            check("addr_be", addr_b, e.addr);
            check("data_be", data_b, e.data_be);
            check("lh_be", lh_b, e.lh_be);
          end
        end
`ifndef WORD_BYTE_STORE_PREFETCH_EN
        if (busy_a) check("ready_while_busy", in_ready_a, 0);
`endif
        if (wr_en_a) wr_cnt++;
        prev_stall = wr_en_a && !mem_ready;
        prev_addr  = addr_a;
        prev_data  = data_a;
        prev_lh    = lh_a;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a request (called at posedge+1); returns the cycle of the accept edge.
  task automatic send(input logic [15:0] w, input logic [15:0] a, input logic [1:0] m,
                      input bit keep_valid, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    in_word = w; in_addr = a; in_mode = m; in_valid = 1'b1;
    for (int i = 0; i < MAX_WAIT && !ok; i++) begin
      ok = in_ready_a;
      step(1);
    end
    if (ok) begin
      acc_cyc = cyc;
      push_request(w, a, m);
    end else begin
      fail_event("accept_timeout");
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Wait for done; lat >= 0 also checks cycles from accept edge to done.
  task automatic wait_done(input int acc_cyc, input int lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        in_valid = 1'b0;
        if (lat >= 0) check("latency", cyc - acc_cyc, lat);
      end
    end
    if (!seen) fail_event("done_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_en_le", wr_en_a, 0);   check("rst_wr_en_be", wr_en_b, 0);
    check("rst_addr_le", addr_a, 0);     check("rst_addr_be", addr_b, 0);
    check("rst_data_le", data_a, 0);     check("rst_data_be", data_b, 0);
    check("rst_lh_le", lh_a, 0);         check("rst_lh_be", lh_b, 0);
    check("rst_busy_le", busy_a, 0);     check("rst_busy_be", busy_b, 0);
    check("rst_done_le", done_a, 0);     check("rst_done_be", done_b, 0);
    check("rst_ready_le", in_ready_a, 0); check("rst_ready_be", in_ready_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc2, snap_wr, snap_done;
    bit ok;
    rst = 1'b1; in_valid = 1'b0; in_word = '0; in_addr = '0; in_mode = '0;
    mem_ready = 1'b0;
    #12;
    check_reset_outputs();
    @(posedge clk); #3;
    rst = 1'b0;
    step(1);
    check("idle_ready", in_ready_a, 1);

    // Reset while stalled in SECOND: everything clears, no done follows.
    ready_mode = 2;
    send(16'h3C3C, 16'h0040, 2'b00, 1'b0, acc);
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT && !ok; i++) begin
      @(negedge clk);
      if (wr_en_a && mem_ready) ok = 1'b1;
    end
    if (!ok) fail_event("first_byte_timeout");
    @(posedge clk); #2;
    check("pre_reset_busy", busy_a, 1);
    check("pre_reset_lh_le", lh_a, 1);
    check("pre_reset_addr", addr_a, 16'h0041);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    ready_mode = 0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    snap_done = done_cnt;
    step(6);
    check("no_done_after_abort", done_cnt - snap_done, 0);

    // Little/big-endian both-byte stores with latency.
    send(16'hA55A, 16'h0100, 2'b00, 1'b0, acc);
    wait_done(acc, 2);
    send(16'h1234, 16'h0FFF, 2'b00, 1'b0, acc);
    wait_done(acc, 2);
    // Single-byte high at the top of memory, and mode 11 as both bytes.
    send(16'hBEEF, 16'hFFFF, 2'b10, 1'b0, acc);
    wait_done(acc, 1);
    send(16'h0102, 16'h0200, 2'b11, 1'b0, acc);
    wait_done(acc, 2);
    send(16'h7788, 16'h0300, 2'b01, 1'b0, acc);
    wait_done(acc, 1);

    // Wrap with backpressure; in_valid left high while busy.
    ready_mode = 2;
    snap_done = done_cnt;
`ifdef WORD_BYTE_STORE_PREFETCH_EN
    send(16'hCAFE, 16'hFFFF, 2'b00, 1'b0, acc);
`else
    send(16'hCAFE, 16'hFFFF, 2'b00, 1'b1, acc);
    in_word = 16'h1111; in_addr = 16'h2222; in_mode = 2'b00;
`endif
    wait_done(acc, -1);
    step(4);
    check("stall_done_count", done_cnt - snap_done, 1);
    check("stall_idle_after", wr_en_a, 0);
    ready_mode = 0;
    step(1);

    // Two requests back to back.
    snap_wr = wr_cnt;
    snap_done = done_cnt;
    send(16'h1357, 16'h0400, 2'b00, 1'b0, acc);
    send(16'h2468, 16'h0500, 2'b00, 1'b0, acc2);
`ifdef WORD_BYTE_STORE_PREFETCH_EN
    check("b2b_accept_gap", acc2 - acc, 2);
    wait_done(acc, 2);
    wait_done(acc2, 2);
    check("b2b_wr_cycles", wr_cnt - snap_wr, 4);
`else
    check("b2b_accept_gap", acc2 - acc, 3);
    wait_done(acc2, 2);
`endif
    check("b2b_done_count", done_cnt - snap_done, 2);

    // Randomized traffic with random backpressure.
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [15:0] w, a;
      logic [1:0]  m;
      w = 16'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      m = 2'($urandom_range(0, 3));
      send(w, a, m, 1'b0, acc);
      step($urandom_range(0, 2));
    end
    ready_mode = 0;
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) step(1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
